fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the decode stage. Reads the decode stage's program counter, issues one request at a time on the instruction-memory bus, and presents the returned word to decode with a one-cycle enable pulse. Discards stale fetches when an interrupt redirects the PC, and honours a downstream hold.

---
 rtl/fetch.sv | 78 +++++++
 tb/tb_fetch.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// fetch: instruction fetch stage; one outstanding imem request, honours flush and hold.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned PCs in a FAULT state instead of masking them.
module fetch #(
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [31:0] i_PC,
    input  logic        i_FLUSH,
    input  logic        i_HOLD,
    output logic        o_IMEM_REQ,
    output logic [31:0] o_IMEM_ADDR,
    input  logic        i_IMEM_GNT,
    input  logic        i_IMEM_RVALID,
    input  logic [31:0] i_IMEM_RDATA,
    output logic [31:0] o_INSTRUCTION,
    output logic        o_EN,
    output logic        o_FAULT
);
    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, VALID, DRAIN
`ifdef FETCH_MISALIGN_CHECK_EN
        , FAULT
`endif
    } state_t;

    state_t state;
    logic   misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = (state == REQ) & (i_PC[1:0] != 2'b00) & ~i_FLUSH;
    assign o_FAULT  = state == FAULT;
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^i_PC[1:0];
    assign misalign      = 1'b0;
    assign o_FAULT       = 1'b0;
`endif

    assign o_IMEM_REQ  = (state == REQ) & ~misalign;
    assign o_IMEM_ADDR = o_IMEM_REQ ? {i_PC[31:2], 2'b00} : 32'h0;
    assign o_EN        = (state == VALID) & ~i_HOLD & ~i_FLUSH;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state         <= IDLE;
            o_INSTRUCTION <= RESET_INSTR;
        end else begin
            case (state)
                IDLE:  state <= REQ;
                REQ: begin
                    if (o_IMEM_REQ && i_IMEM_GNT)
                        state <= i_FLUSH ? DRAIN : WAIT;
`ifdef FETCH_MISALIGN_CHECK_EN
                    else if (misalign)
                        state <= FAULT;
`endif
                end
                WAIT: begin
                    if (i_IMEM_RVALID) begin
                        if (!i_FLUSH)
                            o_INSTRUCTION <= i_IMEM_RDATA;
                        state <= i_FLUSH ? REQ : VALID;
                    end else if (i_FLUSH) begin
                        state <= DRAIN;
                    end
                end
                VALID: state <= (i_FLUSH || !i_HOLD) ? REQ : VALID;
                // the stale beat retires the outstanding request even if a new flush arrives
                DRAIN: state <= i_IMEM_RVALID ? REQ : DRAIN;
`ifdef FETCH_MISALIGN_CHECK_EN
                FAULT: state <= i_FLUSH ? REQ : FAULT;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for fetch with a scoreboard of expected grant addresses and decoded words.
module tb_fetch;
    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic [31:0] i_PC;
    logic        i_FLUSH;
    logic        i_HOLD;
    logic        o_IMEM_REQ;
    logic [31:0] o_IMEM_ADDR;
    logic        i_IMEM_GNT;
    logic        i_IMEM_RVALID;
    logic [31:0] i_IMEM_RDATA;
    logic [31:0] o_INSTRUCTION;
    logic        o_EN;
    logic        o_FAULT;

    int errors = 0;
    int checks = 0;

    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];

    logic        s_en, s_req, s_gnt, s_rv;
    logic [31:0] s_addr;

    int          gdel = 0, rdel = 1, age = 0, lat = 0;
    logic        pend = 1'b0, ovr = 1'b0;
    logic [31:0] paddr = 32'h0;

    fetch dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_PC(i_PC), .i_FLUSH(i_FLUSH), .i_HOLD(i_HOLD),
        .o_IMEM_REQ(o_IMEM_REQ), .o_IMEM_ADDR(o_IMEM_ADDR), .i_IMEM_GNT(i_IMEM_GNT),
        .i_IMEM_RVALID(i_IMEM_RVALID), .i_IMEM_RDATA(i_IMEM_RDATA),
        .o_INSTRUCTION(o_INSTRUCTION), .o_EN(o_EN), .o_FAULT(o_FAULT)
    );

    always #5 i_CLK = ~i_CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h with nothing expected", nm, act);
    endtask

    // monitor: snapshots the bus and retires scoreboard entries
    always @(negedge i_CLK) begin
        s_en   = o_EN;
        s_req  = o_IMEM_REQ;
        s_gnt  = i_IMEM_GNT;
        s_rv   = i_IMEM_RVALID;
        s_addr = o_IMEM_ADDR;
        if (!i_RST) begin
            if (o_IMEM_REQ && i_IMEM_GNT) begin
                if (addr_q.size() == 0) bad("unexpected_grant", o_IMEM_ADDR);
                else chk("grant_addr", o_IMEM_ADDR, addr_q.pop_front());
            end
            if (o_EN) begin
                if (instr_q.size() == 0) bad("unexpected_en", o_INSTRUCTION);
                else chk("decode_instr", o_INSTRUCTION, instr_q.pop_front());
            end
        end
    end

    // memory: grant after gdel request cycles, rvalid rdel cycles after grant
    initial begin
        i_IMEM_GNT = 1'b0;
        i_IMEM_RVALID = 1'b0;
        i_IMEM_RDATA = 32'h0;
        forever begin
            @(posedge i_CLK);
            #2;
            if (i_RST) begin
                pend = 1'b0;
                age = 0;
                i_IMEM_GNT = 1'b0;
                i_IMEM_RVALID = 1'b0;
            end else begin
                if (s_rv) pend = 1'b0;
                if (s_gnt) begin
                    pend = 1'b1;
                    paddr = s_addr;
                    lat = 1;
                    age = 0;
                end else begin
                    if (pend) lat++;
                    age = s_req ? age + 1 : 0;
                end
                i_IMEM_RVALID = pend && lat >= rdel;
                i_IMEM_RDATA = i_IMEM_RVALID ? (ovr ? 32'hDEAD_BEEF : mem(paddr)) : 32'h0;
                if (i_IMEM_RVALID) ovr = 1'b0;
                i_IMEM_GNT = o_IMEM_REQ && !pend && age >= gdel;
            end
        end
    end

    // decode model: PC advances on the edge after an enable
    task automatic nxt();
        @(posedge i_CLK);
        #1;
        if (s_en) i_PC = i_PC + 32'd4;
    endtask

    initial begin
        i_RST = 1'b1;
        i_PC = 32'h0;
        i_FLUSH = 1'b0;
        i_HOLD = 1'b0;
        s_en = 1'b0;
        repeat (3) nxt();
        @(negedge i_CLK);
        chk("rst_en", {31'b0, o_EN}, 32'd0);
        chk("rst_req", {31'b0, o_IMEM_REQ}, 32'd0);
        chk("rst_fault", {31'b0, o_FAULT}, 32'd0);
        chk("rst_instr", o_INSTRUCTION, 32'h0000_0013);
        chk("rst_addr", o_IMEM_ADDR, 32'h0);

        // zero-wait fetches from 0 and 4
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        instr_q.push_back(32'h0050_0093);
        instr_q.push_back(32'h0000_0413);
        nxt();
        i_RST = 1'b0;
        @(negedge i_CLK);
        chk("idle_req", {31'b0, o_IMEM_REQ}, 32'd0);
        nxt();
        @(negedge i_CLK);
        chk("first_req", {31'b0, o_IMEM_REQ}, 32'd1);
        chk("first_addr", o_IMEM_ADDR, 32'h0);
        nxt();
        @(negedge i_CLK);
        chk("wait_en", {31'b0, o_EN}, 32'd0);
        nxt();
        @(negedge i_CLK);
        chk("zw_en", {31'b0, o_EN}, 32'd1);
        nxt();
        @(negedge i_CLK);
        chk("next_req", {31'b0, o_IMEM_REQ}, 32'd1);
        chk("next_addr", o_IMEM_ADDR, 32'h4);
        nxt();
        nxt();
        @(negedge i_CLK);
        chk("zw_en2", {31'b0, o_EN}, 32'd1);

        // slow memory: grant after 3 extra cycles, rvalid 2 cycles after grant
        gdel = 3;
        rdel = 2;
        addr_q.push_back(32'h8);
        instr_q.push_back(32'h0000_0813);
        for (int k = 0; k < 4; k++) begin
            nxt();
            @(negedge i_CLK);
            chk("slow_req", {31'b0, o_IMEM_REQ}, 32'd1);
            chk("slow_addr", o_IMEM_ADDR, 32'h8);
        end
        for (int k = 0; k < 2; k++) begin
            nxt();
            @(negedge i_CLK);
            chk("slow_noreq", {31'b0, o_IMEM_REQ}, 32'd0);
            chk("slow_noen", {31'b0, o_EN}, 32'd0);
        end
        nxt();
        @(negedge i_CLK);
        chk("slow_en", {31'b0, o_EN}, 32'd1);
        gdel = 0;
        rdel = 1;

        // hold for 5 cycles in VALID
        addr_q.push_back(32'hC);
        instr_q.push_back(32'h0000_0C13);
        nxt();
        nxt();
        for (int k = 0; k < 5; k++) begin
            nxt();
            i_HOLD = 1'b1;
            @(negedge i_CLK);
            chk("hold_en", {31'b0, o_EN}, 32'd0);
            chk("hold_req", {31'b0, o_IMEM_REQ}, 32'd0);
            chk("hold_instr", o_INSTRUCTION, 32'h0000_0C13);
        end
        nxt();
        i_HOLD = 1'b0;
        @(negedge i_CLK);
        chk("hold_release_en", {31'b0, o_EN}, 32'd1);

        // flush while waiting; stale DEADBEEF beat two cycles later
        rdel = 3;
        addr_q.push_back(32'h10);
        addr_q.push_back(32'h100);
        instr_q.push_back(32'h0001_0013);
        nxt();
        nxt();
        i_FLUSH = 1'b1;
        ovr = 1'b1;
        @(negedge i_CLK);
        chk("wflush_en", {31'b0, o_EN}, 32'd0);
        nxt();
        i_FLUSH = 1'b0;
        i_PC = 32'h100;
        @(negedge i_CLK);
        chk("drain_req", {31'b0, o_IMEM_REQ}, 32'd0);
        nxt();
        @(negedge i_CLK);
        chk("drain_en", {31'b0, o_EN}, 32'd0);
        chk("drain_req2", {31'b0, o_IMEM_REQ}, 32'd0);
        nxt();
        rdel = 1;
        @(negedge i_CLK);
        chk("redir_req", {31'b0, o_IMEM_REQ}, 32'd1);
        chk("redir_addr", o_IMEM_ADDR, 32'h100);
        chk("stale_dropped", o_INSTRUCTION, 32'h0000_0C13);
        nxt();
        nxt();
        @(negedge i_CLK);
        chk("redir_en", {31'b0, o_EN}, 32'd1);

        // flush coincident with grant
        addr_q.push_back(32'h104);
        addr_q.push_back(32'h200);
        instr_q.push_back(32'h0002_0013);
        nxt();
        i_FLUSH = 1'b1;
        @(negedge i_CLK);
        chk("gflush_req", {31'b0, o_IMEM_REQ}, 32'd1);
        nxt();
        i_FLUSH = 1'b0;
        i_PC = 32'h200;
        @(negedge i_CLK);
        chk("gdrain_en", {31'b0, o_EN}, 32'd0);
        chk("gdrain_req", {31'b0, o_IMEM_REQ}, 32'd0);
        nxt();
        @(negedge i_CLK);
        chk("greq_addr", o_IMEM_ADDR, 32'h200);
        chk("gstale_dropped", o_INSTRUCTION, 32'h0001_0013);
        nxt();
        nxt();
        @(negedge i_CLK);
        chk("gredir_en", {31'b0, o_EN}, 32'd1);

        // misaligned PC
        nxt();
        i_PC = 32'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
        @(negedge i_CLK);
        chk("mis_noreq", {31'b0, o_IMEM_REQ}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            nxt();
            @(negedge i_CLK);
            chk("mis_fault", {31'b0, o_FAULT}, 32'd1);
            chk("mis_req", {31'b0, o_IMEM_REQ}, 32'd0);
            chk("mis_en", {31'b0, o_EN}, 32'd0);
        end
        addr_q.push_back(32'h200);
        instr_q.push_back(32'h0002_0013);
        nxt();
        i_FLUSH = 1'b1;
        i_PC = 32'h200;
        @(negedge i_CLK);
        chk("mis_fault_flush", {31'b0, o_FAULT}, 32'd1);
        nxt();
        i_FLUSH = 1'b0;
        @(negedge i_CLK);
        chk("mis_clear", {31'b0, o_FAULT}, 32'd0);
        chk("mis_refetch", o_IMEM_ADDR, 32'h200);
`else
        addr_q.push_back(32'h100);
        instr_q.push_back(32'h0001_0013);
        @(negedge i_CLK);
        chk("mask_req", {31'b0, o_IMEM_REQ}, 32'd1);
        chk("mask_addr", o_IMEM_ADDR, 32'h100);
        chk("mask_fault", {31'b0, o_FAULT}, 32'd0);
`endif
        nxt();
        nxt();
        @(negedge i_CLK);
        chk("final_en", {31'b0, o_EN}, 32'd1);
        gdel = 1000;
        repeat (4) nxt();
        @(negedge i_CLK);
        chk("addr_q_empty", addr_q.size(), 32'd0);
        chk("instr_q_empty", instr_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
